// File: rtl/sata_phy_pkg.sv
// sata_phy_pkg: shared state encoding and default GTX bring-up timing.
// Also used by the GTX wrapper so both sides agree on the defaults.
package sata_phy_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_SETTLE,
    S_WAIT_DONE,
    S_SATA_RST,
    S_READY,
    S_RETRY,
    S_FAIL
  } state_e;

  localparam int DEF_CPLLRST_CYCLES  = 8;
  localparam int DEF_TXPMARESET_TIME = 1;
  localparam int DEF_RXEYERESET_TIME = 35;
  localparam int DEF_RST_TIMER_LIMIT = 8;
  localparam int DEF_PARTRST_CYCLES  = 8;
  localparam int DEF_TIMEOUT_CYCLES  = 65535;
  localparam int DEF_MAX_RETRIES     = 3;

  function automatic int cmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sata_sync_bits.sv
// sata_sync_bits: two-flop synchroniser for slow async status bits.
// Resets to 0 so lock/done never look asserted out of reset.
module sata_sync_bits #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the async inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sata_phy_rst_seq.sv
// sata_phy_rst_seq: GTX bring-up/reset sequencer with timeouts, retries,
// lock-loss re-init and per-lane OOB partial-reset handshakes.
module sata_phy_rst_seq
  import sata_phy_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int CPLLRST_CYCLES  = DEF_CPLLRST_CYCLES,
  parameter int TXPMARESET_TIME = DEF_TXPMARESET_TIME,
  parameter int RXEYERESET_TIME = DEF_RXEYERESET_TIME,
  parameter int RST_TIMER_LIMIT = DEF_RST_TIMER_LIMIT,
  parameter int PARTRST_CYCLES  = DEF_PARTRST_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
  localparam int RTW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart_i,
  input  logic [NUM_LANES-1:0] cplllock_i,
  input  logic                 usrpll_locked_i,
  input  logic [NUM_LANES-1:0] txresetdone_i,
  input  logic [NUM_LANES-1:0] rxresetdone_i,
  input  logic [NUM_LANES-1:0] txpcsreset_req_i,
  input  logic [NUM_LANES-1:0] rxreset_req_i,
  output logic [NUM_LANES-1:0] cpllreset_o,
  output logic [NUM_LANES-1:0] txreset_o,
  output logic [NUM_LANES-1:0] rxreset_o,
  output logic [NUM_LANES-1:0] txuserrdy_o,
  output logic [NUM_LANES-1:0] rxuserrdy_o,
  output logic [NUM_LANES-1:0] txpcsreset_o,
  output logic [NUM_LANES-1:0] recal_tx_done_o,
  output logic [NUM_LANES-1:0] rxreset_ack_o,
  output logic                 sata_rst_o,
  output logic                 gtx_ready_o,
  output logic                 gtx_configured_o,
  output logic                 fail_o,
  output logic [RTW-1:0]       retry_cnt_o
);

  localparam int CW = $clog2(cmax(cmax(TIMEOUT_CYCLES, CPLLRST_CYCLES),
                                  RST_TIMER_LIMIT) + 1);
  localparam int TW = $clog2(cmax(TXPMARESET_TIME, 1) + 1);
  localparam int XW = $clog2(cmax(RXEYERESET_TIME, 1) + 1);
  localparam int PW = $clog2(cmax(PARTRST_CYCLES, 1) + 1);
  localparam int SW = 3 * NUM_LANES + 1;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [SW-1:0]        sync_s;
  logic [NUM_LANES-1:0] cpl_s;
  logic [NUM_LANES-1:0] txd_s;
  logic [NUM_LANES-1:0] rxd_s;
  logic                 usr_s;

  sata_sync_bits #(
    .WIDTH (SW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({usrpll_locked_i, rxresetdone_i,
             txresetdone_i, cplllock_i}),
    .q_o   (sync_s)
  );

  assign cpl_s = sync_s[NUM_LANES-1:0];
  assign txd_s = sync_s[2*NUM_LANES-1:NUM_LANES];
  assign rxd_s = sync_s[3*NUM_LANES-1:2*NUM_LANES];
  assign usr_s = sync_s[SW-1];

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  txc_q, txc_d;
  logic [XW-1:0]  rxc_q, rxc_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic           loss_q;

  logic lock_ok, done_ok, in_run, lost, tmo;

  assign lock_ok = (&cpl_s) & usr_s;
  assign done_ok = (&txd_s) & (&rxd_s);
  assign in_run  = (state_q == S_SETTLE) || (state_q == S_WAIT_DONE) ||
                   (state_q == S_SATA_RST) || (state_q == S_READY);
  assign lost    = !lock_ok && loss_q && in_run;
  assign tmo     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // State, timers and retry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
      txc_q   <= '0;
      rxc_q   <= '0;
      retry_q <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txc_q   <= txc_d;
      rxc_q   <= rxc_d;
      retry_q <= retry_d;
      loss_q  <= !lock_ok;
    end
  end

  // Next state; restart overrides lock loss and timeouts
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    txc_d   = txc_q;
    rxc_d   = rxc_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CW'(CPLLRST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_ok)  state_d = S_SETTLE;
        else if (tmo) state_d = S_RETRY;
      end
      S_SETTLE: begin
        if (txc_q != TW'(TXPMARESET_TIME)) txc_d = txc_q + TW'(1);
        if (rxc_q != XW'(RXEYERESET_TIME)) rxc_d = rxc_q + XW'(1);
        if (txc_q == TW'(TXPMARESET_TIME) &&
            rxc_q == XW'(RXEYERESET_TIME)) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_ok)  state_d = S_SATA_RST;
        else if (tmo) state_d = S_RETRY;
      end
      S_SATA_RST: begin
        if (cnt_q == CW'(RST_TIMER_LIMIT - 1)) state_d = S_READY;
      end
      S_READY: ;
      S_RETRY: begin
        retry_d = retry_q + RTW'(1);
        state_d = (retry_d == RTW'(MAX_RETRIES)) ? S_FAIL : S_PLL_RST;
      end
      S_FAIL: ;
    endcase
    if (lost) state_d = S_PLL_RST;
    if (state_d == S_READY && state_q != S_READY) retry_d = '0;
    if (restart_i) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end
    if (state_d != state_q || restart_i) cnt_d = '0;
    if (state_d != S_SETTLE) begin
      txc_d = '0;
      rxc_d = '0;
    end
  end

  logic cpll_q, trst_q, urdy_q, srst_q, rdy_q, cfg_q, fail_q;
  logic cpll_c, trst_c, urdy_c;

  // Output decode of the current state
  always_comb begin
    cpll_c = 1'b0;
    trst_c = 1'b0;
    urdy_c = 1'b0;
    unique case (state_q)
      S_PLL_RST, S_RETRY, S_FAIL: begin
        cpll_c = 1'b1;
        trst_c = 1'b1;
      end
      S_WAIT_LOCK: trst_c = 1'b1;
      S_SETTLE: ;
      S_WAIT_DONE, S_SATA_RST, S_READY: urdy_c = 1'b1;
    endcase
  end

  // Registered GTX controls and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpll_q <= 1'b1;
      trst_q <= 1'b1;
      urdy_q <= 1'b0;
      srst_q <= 1'b0;
      rdy_q  <= 1'b0;
      cfg_q  <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      cpll_q <= cpll_c;
      trst_q <= trst_c;
      urdy_q <= urdy_c;
      srst_q <= (state_q == S_SATA_RST);
      rdy_q  <= (state_q == S_READY);
      cfg_q  <= cfg_q | (state_q == S_READY);
      fail_q <= (state_q == S_FAIL);
    end
  end

  logic [NUM_LANES-1:0] tp_v, ta_v, rp_v, ra_v;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [PW-1:0] tc_q, rc_q;
    logic          tp_q, ta_q, rp_q, ra_q;

    // Partial-reset pulse then ack, only while READY
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tc_q <= '0;
        tp_q <= 1'b0;
        ta_q <= 1'b0;
        rc_q <= '0;
        rp_q <= 1'b0;
        ra_q <= 1'b0;
      end else begin
        if (state_q == S_READY && txpcsreset_req_i[i]) begin
          if (tc_q != PW'(PARTRST_CYCLES)) begin
            tc_q <= tc_q + PW'(1);
            tp_q <= 1'b1;
            ta_q <= 1'b0;
          end else begin
            tp_q <= 1'b0;
            ta_q <= 1'b1;
          end
        end else begin
          tc_q <= '0;
          tp_q <= 1'b0;
          ta_q <= 1'b0;
        end
        if (state_q == S_READY && rxreset_req_i[i]) begin
          if (rc_q != PW'(PARTRST_CYCLES)) begin
            rc_q <= rc_q + PW'(1);
            rp_q <= 1'b1;
            ra_q <= 1'b0;
          end else begin
            rp_q <= 1'b0;
            ra_q <= 1'b1;
          end
        end else begin
          rc_q <= '0;
          rp_q <= 1'b0;
          ra_q <= 1'b0;
        end
      end
    end

    assign tp_v[i] = tp_q;
    assign ta_v[i] = ta_q;
    assign rp_v[i] = rp_q;
    assign ra_v[i] = ra_q;
  end

  assign cpllreset_o      = {NUM_LANES{cpll_q}};
  assign txreset_o        = {NUM_LANES{trst_q}};
  assign rxreset_o        = {NUM_LANES{trst_q}} | rp_v;
  assign txuserrdy_o      = {NUM_LANES{urdy_q}};
  assign rxuserrdy_o      = {NUM_LANES{urdy_q}};
  assign txpcsreset_o     = tp_v;
  assign recal_tx_done_o  = ta_v;
  assign rxreset_ack_o    = ra_v;
  assign sata_rst_o       = srst_q;
  assign gtx_ready_o      = rdy_q;
  assign gtx_configured_o = cfg_q;
  assign fail_o           = fail_q;
  assign retry_cnt_o      = retry_q;

endmodule
